// File: rtl/setup_config.sv
// setup_config: keypad-driven editor for the alarm setup record.
//
// Ports:
//   clk            - single clock, rising edge
//   rst            - synchronous, active-low reset
//   setup_on       - session request, held high for the whole session
//   key_valid      - one-cycle strobe qualifying key_code
//   key_code       - 0x0-0x9 digit, 0xA skip, 0xE confirm, other codes ignored
//   data_setup_old - current configuration
//   data_setup_new - edited configuration, valid while setup_end is high
//   setup_end      - one-cycle pulse closing a session (commit or timeout)
//   bcd_out        - display digits BCD3..BCD0
//   bcd_enable     - display enable
package setup_config_pkg;

  typedef struct packed {
    logic       status;
    logic [3:0] digit1;
    logic [3:0] digit2;
    logic [3:0] digit3;
    logic [3:0] digit4;
  } pin_t;

  typedef struct packed {
    logic       bip_status;
    logic [6:0] bip_time;
    logic [6:0] tranca_aut_time;
    pin_t       master_pin;
    pin_t       pin1;
    pin_t       pin2;
    pin_t       pin3;
    pin_t       pin4;
  } setupPac_t;

  typedef struct packed {
    logic [3:0] bcd3;
    logic [3:0] bcd2;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
  } bcdPac_t;

  localparam logic [3:0] BcdBlank = 4'hC;

  localparam setupPac_t SetupDefault = '{
    bip_status:      1'b1,
    bip_time:        7'd5,
    tranca_aut_time: 7'd5,
    master_pin:      '{status: 1'b1, digit1: 4'd1, digit2: 4'd2, digit3: 4'd3, digit4: 4'd4},
    pin1:            '{status: 1'b1, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0},
    pin2:            '{status: 1'b0, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0},
    pin3:            '{status: 1'b0, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0},
    pin4:            '{status: 1'b0, digit1: 4'd0, digit2: 4'd0, digit3: 4'd0, digit4: 4'd0}
  };

endpackage

module setup_config
  import setup_config_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 1000,
  parameter int unsigned TIMEOUT_S   = 30,
  parameter int unsigned TIME_MIN    = 3,
  parameter int unsigned TIME_MAX    = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       setup_on,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  setupPac_t  data_setup_old,
  output setupPac_t  data_setup_new,
  output logic       setup_end,
  output bcdPac_t    bcd_out,
  output logic       bcd_enable
);

  localparam logic [31:0] TimeoutLimit = 32'(TIMEOUT_S * CLK_FREQ_HZ);
  localparam logic [6:0]  TimeMin      = 7'(TIME_MIN);
  localparam logic [6:0]  TimeMax      = 7'(TIME_MAX);
  localparam logic [3:0]  KeySkip      = 4'hA;
  localparam logic [3:0]  KeyConfirm   = 4'hE;

  typedef enum logic [3:0] {
    StIdle, StLoad, StBipEn, StBipT, StTraT, StPin1, StPin2, StPin3, StPin4, StDone
  } state_e;

  function automatic state_e next_field(input state_e s);
    state_e n;
    case (s)
      StBipEn: n = StBipT;
      StBipT:  n = StTraT;
      StTraT:  n = StPin1;
      StPin1:  n = StPin2;
      StPin2:  n = StPin3;
      StPin3:  n = StPin4;
      StPin4:  n = StDone;
      default: n = StIdle;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] field_limit(input state_e s);
    logic [2:0] l;
    case (s)
      StBipEn:        l = 3'd1;
      StBipT, StTraT: l = 3'd2;
      default:        l = 3'd4;
    endcase
    return l;
  endfunction

  function automatic logic [3:0] field_idx(input state_e s);
    logic [3:0] i;
    case (s)
      StBipEn: i = 4'd1;
      StBipT:  i = 4'd2;
      StTraT:  i = 4'd3;
      StPin1:  i = 4'd4;
      StPin2:  i = 4'd5;
      StPin3:  i = 4'd6;
      StPin4:  i = 4'd7;
      default: i = BcdBlank;
    endcase
    return i;
  endfunction

  state_e          state_q, state_d;
  setupPac_t       work_q, work_d;
  // Digit buffer is a shift register: dig_q[0] is the most recent digit.
  logic [3:0][3:0] dig_q, dig_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [31:0]     tmo_q, tmo_d;
  // Set once setup_on has been seen low; a new session needs it.
  logic            armed_q, armed_d;
  logic            setup_end_q, setup_end_d;
  setupPac_t       data_new_q, data_new_d;
  bcdPac_t         bcd_q, bcd_d;
  logic            bcd_en_q, bcd_en_d;

  logic [6:0] tval;
  logic       time_ok;
  pin_t       pin_new;
  logic       advance, reject;

  // One buffered digit is taken as the value itself.
  assign tval = (cnt_q == 3'd2) ? ({3'b0, dig_q[1]} * 7'd10 + {3'b0, dig_q[0]})
                                : {3'b0, dig_q[0]};
  assign time_ok = (cnt_q != 3'd0) && (tval >= TimeMin) && (tval <= TimeMax);
  assign pin_new = '{status: 1'b1, digit1: dig_q[3], digit2: dig_q[2],
                     digit3: dig_q[1], digit4: dig_q[0]};

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    dig_d       = dig_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    armed_d     = armed_q;
    setup_end_d = 1'b0;
    data_new_d  = data_new_q;
    advance     = 1'b0;
    reject      = 1'b0;

    if (!setup_on) armed_d = 1'b1;

    case (state_q)
      StIdle: begin
        dig_d = '0;
        cnt_d = '0;
        tmo_d = '0;
        if (setup_on && armed_q) state_d = StLoad;
      end
      StLoad: begin
        work_d  = data_setup_old;
        dig_d   = '0;
        cnt_d   = '0;
        tmo_d   = '0;
        armed_d = 1'b0;
        state_d = StBipEn;
      end
      StDone: begin
        setup_end_d = 1'b1;
        data_new_d  = work_q;
        dig_d       = '0;
        cnt_d       = '0;
        tmo_d       = '0;
        state_d     = StIdle;
      end
      default: begin
        if (!setup_on) begin
          state_d = StIdle;
          dig_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
        end else if (key_valid) begin
          tmo_d = '0;
          if (key_code <= 4'd9) begin
            if (cnt_q < field_limit(state_q)) begin
              dig_d = {dig_q[2:0], key_code};
              cnt_d = cnt_q + 3'd1;
            end
          end else if (key_code == KeySkip) begin
            advance = 1'b1;
          end else if (key_code == KeyConfirm) begin
            case (state_q)
              StBipEn: begin
                if (cnt_q == 3'd1 && dig_q[0] <= 4'd1) begin
                  work_d.bip_status = dig_q[0][0];
                  advance = 1'b1;
                end else begin
                  reject = 1'b1;
                end
              end
              StBipT: begin
                if (time_ok) begin
                  work_d.bip_time = tval;
                  advance = 1'b1;
                end else begin
                  reject = 1'b1;
                end
              end
              StTraT: begin
                if (time_ok) begin
                  work_d.tranca_aut_time = tval;
                  advance = 1'b1;
                end else begin
                  reject = 1'b1;
                end
              end
              default: begin
                if (cnt_q == 3'd4) begin
                  case (state_q)
                    StPin1:  work_d.pin1 = pin_new;
                    StPin2:  work_d.pin2 = pin_new;
                    StPin3:  work_d.pin3 = pin_new;
                    default: work_d.pin4 = pin_new;
                  endcase
                  advance = 1'b1;
                end else if (cnt_q == 3'd0) begin
                  // Empty confirm disables the PIN, except pin1 which stays as is.
                  case (state_q)
                    StPin2:  work_d.pin2.status = 1'b0;
                    StPin3:  work_d.pin3.status = 1'b0;
                    StPin4:  work_d.pin4.status = 1'b0;
                    default: ;
                  endcase
                  advance = 1'b1;
                end else begin
                  reject = 1'b1;
                end
              end
            endcase
          end
        end else if (tmo_q >= TimeoutLimit) begin
          // Abort: discard edits, still close the session with a pulse.
          work_d  = data_setup_old;
          dig_d   = '0;
          cnt_d   = '0;
          tmo_d   = '0;
          state_d = StDone;
        end else begin
          tmo_d = tmo_q + 32'd1;
        end

        if (advance) state_d = next_field(state_q);
        if (advance || reject) begin
          dig_d = '0;
          cnt_d = '0;
        end
      end
    endcase
  end

  // Display is built from next-state values so it tracks the registered state.
  always_comb begin
    bcd_d    = '{bcd3: BcdBlank, bcd2: BcdBlank, bcd1: BcdBlank, bcd0: BcdBlank};
    bcd_en_d = 1'b0;
    if (state_d != StIdle) begin
      bcd_en_d   = 1'b1;
      bcd_d.bcd3 = field_idx(state_d);
      if (cnt_d >= 3'd1) bcd_d.bcd0 = dig_d[0];
      if (cnt_d >= 3'd2) bcd_d.bcd1 = dig_d[1];
      if (cnt_d >= 3'd3) bcd_d.bcd2 = dig_d[2];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      work_q      <= SetupDefault;
      dig_q       <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      armed_q     <= 1'b0;
      setup_end_q <= 1'b0;
      data_new_q  <= SetupDefault;
      bcd_q       <= '{bcd3: BcdBlank, bcd2: BcdBlank, bcd1: BcdBlank, bcd0: BcdBlank};
      bcd_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      dig_q       <= dig_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      armed_q     <= armed_d;
      setup_end_q <= setup_end_d;
      data_new_q  <= data_new_d;
      bcd_q       <= bcd_d;
      bcd_en_q    <= bcd_en_d;
    end
  end

  assign data_setup_new = data_new_q;
  assign setup_end      = setup_end_q;
  assign bcd_out        = bcd_q;
  assign bcd_enable     = bcd_en_q;

endmodule

// File: tb/tb_setup_config.sv
// Directed self-checking bench for setup_config.
module tb_setup_config;
  import setup_config_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       setup_on;
  logic       key_valid;
  logic [3:0] key_code;
  setupPac_t  data_setup_old;
  setupPac_t  data_setup_new;
  logic       setup_end;
  bcdPac_t    bcd_out;
  logic       bcd_enable;

  int n_checks = 0;
  int n_fail   = 0;
  int end_cnt  = 0;

  setup_config #(
    .CLK_FREQ_HZ(1000),
    .TIMEOUT_S  (30),
    .TIME_MIN   (3),
    .TIME_MAX   (60)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .setup_on      (setup_on),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .data_setup_old(data_setup_old),
    .data_setup_new(data_setup_new),
    .setup_end     (setup_end),
    .bcd_out       (bcd_out),
    .bcd_enable    (bcd_enable)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (setup_end) end_cnt <= end_cnt + 1;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic pin_t mk_pin(input logic s, input logic [15:0] d);
    pin_t p;
    p.status = s;
    p.digit1 = d[15:12];
    p.digit2 = d[11:8];
    p.digit3 = d[7:4];
    p.digit4 = d[3:0];
    return p;
  endfunction

  function automatic setupPac_t mk_cfg(input logic be, input logic [6:0] bt, input logic [6:0] tt,
                                       input pin_t m, input pin_t p1, input pin_t p2,
                                       input pin_t p3, input pin_t p4);
    setupPac_t c;
    c.bip_status      = be;
    c.bip_time        = bt;
    c.tranca_aut_time = tt;
    c.master_pin      = m;
    c.pin1            = p1;
    c.pin2            = p2;
    c.pin3            = p3;
    c.pin4            = p4;
    return c;
  endfunction

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = k;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'h0;
    @(negedge clk);
  endtask

  // Presses n keys taken from the low nibbles of codes, most significant first.
  task automatic press_seq(input logic [31:0] codes, input int n);
    for (int i = n - 1; i >= 0; i--) press(codes[i*4 +: 4]);
  endtask

  task automatic start_session();
    @(negedge clk);
    setup_on = 1'b0;
    @(negedge clk);
    setup_on = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  setupPac_t cfg_def, cfg_o1, cfg_o2, exp1, exp2;
  int        ends0;
  int        lat;

  initial begin
    cfg_def = mk_cfg(1'b1, 7'd5, 7'd5, mk_pin(1'b1, 16'h1234), mk_pin(1'b1, 16'h0000),
                     mk_pin(1'b0, 16'h0000), mk_pin(1'b0, 16'h0000), mk_pin(1'b0, 16'h0000));
    cfg_o1  = mk_cfg(1'b0, 7'd15, 7'd25, mk_pin(1'b1, 16'h9876), mk_pin(1'b1, 16'h1111),
                     mk_pin(1'b1, 16'h2222), mk_pin(1'b1, 16'h3333), mk_pin(1'b0, 16'h4444));
    cfg_o2  = mk_cfg(1'b1, 7'd33, 7'd44, mk_pin(1'b1, 16'h5555), mk_pin(1'b1, 16'h6666),
                     mk_pin(1'b0, 16'h7777), mk_pin(1'b0, 16'h8888), mk_pin(1'b1, 16'h9999));
    exp1    = mk_cfg(1'b1, 7'd10, 7'd20, mk_pin(1'b1, 16'h9876), mk_pin(1'b1, 16'h5678),
                     mk_pin(1'b0, 16'h2222), mk_pin(1'b1, 16'h3333), mk_pin(1'b0, 16'h4444));
    exp2    = mk_cfg(1'b0, 7'd4, 7'd60, mk_pin(1'b1, 16'h9876), mk_pin(1'b1, 16'h1111),
                     mk_pin(1'b1, 16'h1234), mk_pin(1'b1, 16'h3333), mk_pin(1'b0, 16'h4444));

    rst            = 1'b0;
    setup_on       = 1'b0;
    key_valid      = 1'b0;
    key_code       = 4'h0;
    data_setup_old = cfg_o1;
    repeat (2) @(negedge clk);

    // Reset state
    check_eq("rst_setup_end", 128'(setup_end), 128'(1'b0));
    check_eq("rst_bcd_en", 128'(bcd_enable), 128'(1'b0));
    check_eq("rst_bcd", 128'(bcd_out), 128'(16'hCCCC));
    check_eq("rst_data", 128'(data_setup_new), 128'(cfg_def));
    rst = 1'b1;

    // Full edit session
    start_session();
    check_eq("s1_enter", 128'(bcd_out), 128'(16'h1CCC));
    check_eq("s1_en", 128'(bcd_enable), 128'(1'b1));
    ends0 = end_cnt;
    press(4'h1);
    check_eq("s1_digit", 128'(bcd_out), 128'(16'h1CC1));
    press(4'hE);
    check_eq("s1_bipt", 128'(bcd_out), 128'(16'h2CCC));
    press_seq(32'h10, 2);
    check_eq("s1_two_dig", 128'(bcd_out), 128'(16'h2C10));
    press(4'hE);
    press_seq(32'h20E, 3);
    check_eq("s1_pin1", 128'(bcd_out), 128'(16'h4CCC));
    press_seq(32'h5678, 4);
    check_eq("s1_pin_disp", 128'(bcd_out), 128'(16'h4678));
    press(4'hE);
    press(4'hE);
    check_eq("s1_pin3", 128'(bcd_out), 128'(16'h6CCC));
    press(4'hA);
    check_eq("s1_pin4", 128'(bcd_out), 128'(16'h7CCC));
    press(4'hA);
    repeat (3) @(negedge clk);
    check_eq("s1_pulses", 128'(end_cnt - ends0), 128'(1));
    check_eq("s1_data", 128'(data_setup_new), 128'(exp1));
    check_eq("s1_idle_en", 128'(bcd_enable), 128'(1'b0));

    // Output holds; no restart while setup_on stays high
    data_setup_old = cfg_o2;
    repeat (6) @(negedge clk);
    check_eq("hold_data", 128'(data_setup_new), 128'(exp1));
    check_eq("no_rearm", 128'(bcd_enable), 128'(1'b0));
    data_setup_old = cfg_o1;

    // Range checks and partial PIN
    start_session();
    ends0 = end_cnt;
    press(4'hB);
    check_eq("s2_ignored", 128'(bcd_out), 128'(16'h1CCC));
    press_seq(32'h2E, 2);
    check_eq("s2_bip_rej", 128'(bcd_out), 128'(16'h1CCC));
    press_seq(32'h01, 2);
    check_eq("s2_bip_lim", 128'(bcd_out), 128'(16'h1CC0));
    press(4'hE);
    check_eq("s2_bip_ok", 128'(bcd_out), 128'(16'h2CCC));
    press_seq(32'h99E, 3);
    check_eq("s2_99_rej", 128'(bcd_out), 128'(16'h2CCC));
    press_seq(32'h4E, 2);
    check_eq("s2_4_ok", 128'(bcd_out), 128'(16'h3CCC));
    press_seq(32'h61E, 3);
    check_eq("s2_61_rej", 128'(bcd_out), 128'(16'h3CCC));
    press_seq(32'h2E, 2);
    check_eq("s2_2_rej", 128'(bcd_out), 128'(16'h3CCC));
    press_seq(32'h60E, 3);
    check_eq("s2_60_ok", 128'(bcd_out), 128'(16'h4CCC));
    press(4'hE);
    check_eq("s2_pin1_empty", 128'(bcd_out), 128'(16'h5CCC));
    press_seq(32'h12E, 3);
    check_eq("s2_pin_part", 128'(bcd_out), 128'(16'h5CCC));
    press_seq(32'h12345, 5);
    check_eq("s2_pin_excess", 128'(bcd_out), 128'(16'h5234));
    press(4'hE);
    check_eq("s2_pin3", 128'(bcd_out), 128'(16'h6CCC));
    press_seq(32'hAA, 2);
    repeat (3) @(negedge clk);
    check_eq("s2_pulses", 128'(end_cnt - ends0), 128'(1));
    check_eq("s2_data", 128'(data_setup_new), 128'(exp2));

    // Inactivity timeout
    start_session();
    ends0 = end_cnt;
    lat   = -1;
    for (int i = 1; i <= 31000; i++) begin
      @(negedge clk);
      if (setup_end) begin
        lat = i;
        break;
      end
    end
    check_eq("tmo_seen", 128'(lat != -1), 128'(1'b1));
    check_eq("tmo_latency", 128'(lat >= 29990 && lat <= 30010), 128'(1'b1));
    check_eq("tmo_data", 128'(data_setup_new), 128'(cfg_o1));
    repeat (3) @(negedge clk);
    check_eq("tmo_pulses", 128'(end_cnt - ends0), 128'(1));

    // setup_on abort in F_PIN3
    start_session();
    ends0 = end_cnt;
    press_seq(32'h1EAAAA, 6);
    check_eq("ab_pin3", 128'(bcd_out), 128'(16'h6CCC));
    setup_on = 1'b0;
    @(negedge clk);
    check_eq("ab_bcd_en", 128'(bcd_enable), 128'(1'b0));
    repeat (4) @(negedge clk);
    check_eq("ab_pulses", 128'(end_cnt - ends0), 128'(0));
    check_eq("ab_data", 128'(data_setup_new), 128'(cfg_o1));

    // Reset in F_TRAT
    start_session();
    ends0 = end_cnt;
    press_seq(32'hAA, 2);
    check_eq("rs_trat", 128'(bcd_out), 128'(16'h3CCC));
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_eq("rs_bcd_en", 128'(bcd_enable), 128'(1'b0));
    check_eq("rs_bcd", 128'(bcd_out), 128'(16'hCCCC));
    check_eq("rs_data", 128'(data_setup_new), 128'(cfg_def));
    repeat (5) @(negedge clk);
    check_eq("rs_no_rearm", 128'(bcd_enable), 128'(1'b0));
    check_eq("rs_pulses", 128'(end_cnt - ends0), 128'(0));
    start_session();
    check_eq("rs_restart", 128'(bcd_out), 128'(16'h1CCC));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
